// File: rtl/mrd_sink_pkg.sv
`default_nettype none
// ============================================================================
// mrd_sink_pkg : shared types, defaults and helpers for the banked mrd sink
// Rev 1.0      : initial release
// ============================================================================
package mrd_sink_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FRAME = 1'b1
  } sink_state_e;

  localparam int DEF_NBANK     = 7;
  localparam int DEF_WADDR     = 8;
  localparam int DEF_WCNT      = 12;
  localparam int DEF_WDATA     = 36;
  localparam int DEF_OVT_LIMIT = 2047;
  localparam int DEF_SOP_LEAD  = 3;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // (len/4 + len/2) never exceeds len, so the caller may truncate to len's width
  function automatic logic [31:0] thr34(input logic [31:0] len);
    return (len >> 2) + (len >> 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mrd_bank_rr.sv
`default_nettype none
// ============================================================================
// mrd_bank_rr : round-robin bank index / shared address generator
// Rev 1.0     : initial release
// ============================================================================
module mrd_bank_rr
  import mrd_sink_pkg::*;
#(
  parameter int NBANK = DEF_NBANK,
  parameter int wADDR = DEF_WADDR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             advance,
  output logic [wADDR-1:0] addr,
  output logic [NBANK-1:0] onehot
);

  localparam int            IW   = idx_w(NBANK);
  localparam logic [IW-1:0] LAST = IW'(NBANK - 1);

  logic [IW-1:0]    idx_q, idx_d;
  logic [wADDR-1:0] addr_q, addr_d;
  logic [IW-1:0]    idx;

  // clear takes effect combinationally so the restarting sample itself lands on bank 0
  always_comb begin
    idx    = clear ? '0 : idx_q;
    addr   = clear ? '0 : addr_q;
    idx_d  = idx;
    addr_d = addr;
    if (advance) begin
      if (idx == LAST) begin
        idx_d  = '0;
        addr_d = addr + wADDR'(1);
      end else begin
        idx_d  = idx + IW'(1);
      end
    end
    onehot = '0;
    for (int i = 0; i < NBANK; i++) begin
      onehot[NBANK-1-i] = (idx == IW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= '0;
      addr_q <= '0;
    end else begin
      idx_q  <= idx_d;
      addr_q <= addr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mrd_sink_banked.sv
`default_nettype none
// ============================================================================
// mrd_sink_banked : banked sample sink with length check, watchdog, cfg check
// Rev 1.0         : initial release
// ============================================================================
module mrd_sink_banked
  import mrd_sink_pkg::*;
#(
  parameter int NBANK     = DEF_NBANK,
  parameter int wADDR     = DEF_WADDR,
  parameter int wCNT      = DEF_WCNT,
  parameter int wDATA     = DEF_WDATA,
  parameter int OVT_LIMIT = DEF_OVT_LIMIT,
  parameter int SOP_LEAD  = DEF_SOP_LEAD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fsm_is_sink,
  input  logic [wCNT-1:0]  frame_len,
  input  logic             in_valid,
  input  logic             in_sop,
  input  logic [wDATA-1:0] in_data,
  output logic [NBANK-1:0] wr_en,
  output logic [wADDR-1:0] wr_addr,
  output logic [wDATA-1:0] wr_data,
  output logic             sink_3_4,
  output logic             twdl_sop_sink,
  output logic             frame_done,
  output logic             frame_err,
  output logic             overTime,
  output logic             cfg_err
);

  localparam int              OW         = $clog2(OVT_LIMIT + 1);
  localparam logic [OW-1:0]   OVT_MAX    = OW'(OVT_LIMIT);
  localparam logic [63:0]     CAP        = 64'(NBANK) << wADDR;
  localparam logic [wCNT-1:0] SOP_LEAD_C = wCNT'(SOP_LEAD);

  sink_state_e      state_q, state_d;
  logic [wCNT-1:0]  cnt_q, cnt_d;
  logic [wCNT-1:0]  len_q, len_d;
  logic [wCNT-1:0]  thr_q, thr_d;
  logic             cfg_err_q, cfg_err_d;
  logic             err_seen_q, err_seen_d;
  logic [OW-1:0]    ovt_cnt_q, ovt_cnt_d;
  logic             over_time_q, over_time_d;
  logic [NBANK-1:0] wr_en_q, wr_en_d;
  logic [wADDR-1:0] wr_addr_q, wr_addr_d;
  logic [wDATA-1:0] wr_data_q, wr_data_d;
  logic             sink_3_4_q, sink_3_4_d;
  logic             twdl_q, twdl_d;
  logic             done_q, done_d;
  logic             frame_err_q, frame_err_d;

  logic             start;
  logic             idle;
  logic [wCNT-1:0]  k;
  logic             err_base;
  logic             drop;
  logic             keep;
  logic             short_end;
  logic [wADDR-1:0] bank_addr;
  logic [NBANK-1:0] bank_onehot;

  assign start = in_valid & ((state_q == IDLE) | in_sop);

  mrd_bank_rr #(
    .NBANK (NBANK),
    .wADDR (wADDR)
  ) u_bank_rr (
    .clk     (clk),
    .rst     (rst),
    .clear   (start),
    .advance (in_valid),
    .addr    (bank_addr),
    .onehot  (bank_onehot)
  );

  always_comb begin
    idle       = (state_q == IDLE);
    k          = start ? '0 : cnt_q;
    err_base   = start ? 1'b0 : err_seen_q;
    drop       = in_valid & (cfg_err_q | (k >= len_q));
    keep       = in_valid & ~drop;
    // a gap or an SOP restart closes the current frame; short frames are flagged once
    short_end  = ~idle & ~err_seen_q & (cnt_q < len_q) & (~in_valid | in_sop);

    state_d    = in_valid ? FRAME : IDLE;
    cnt_d      = in_valid ? (k + wCNT'(1)) : cnt_q;
    len_d      = idle ? frame_len : len_q;
    thr_d      = idle ? wCNT'(thr34(32'(frame_len))) : thr_q;
    cfg_err_d  = idle ? ((frame_len == '0) | (64'(frame_len) > CAP)) : cfg_err_q;
    err_seen_d = err_base | drop;

    wr_en_d     = keep ? bank_onehot : '0;
    wr_addr_d   = keep ? bank_addr : wr_addr_q;
    wr_data_d   = keep ? in_data : wr_data_q;
    sink_3_4_d  = keep & (thr_q != '0) & (k == thr_q - wCNT'(1));
    twdl_d      = keep & (thr_q > SOP_LEAD_C) & (k == thr_q - SOP_LEAD_C - wCNT'(1));
    done_d      = keep & (k == len_q - wCNT'(1));
    frame_err_d = short_end | (drop & ~err_base);

    if (!fsm_is_sink) begin
      ovt_cnt_d   = '0;
      over_time_d = 1'b0;
    end else begin
      ovt_cnt_d   = (ovt_cnt_q == OVT_MAX) ? ovt_cnt_q : ovt_cnt_q + OW'(1);
      over_time_d = over_time_q | (ovt_cnt_q == OVT_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      len_q       <= frame_len;
      thr_q       <= wCNT'(thr34(32'(frame_len)));
      cfg_err_q   <= 1'b0;
      err_seen_q  <= 1'b0;
      ovt_cnt_q   <= '0;
      over_time_q <= 1'b0;
      wr_en_q     <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      sink_3_4_q  <= 1'b0;
      twdl_q      <= 1'b0;
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      thr_q       <= thr_d;
      cfg_err_q   <= cfg_err_d;
      err_seen_q  <= err_seen_d;
      ovt_cnt_q   <= ovt_cnt_d;
      over_time_q <= over_time_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      sink_3_4_q  <= sink_3_4_d;
      twdl_q      <= twdl_d;
      done_q      <= done_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign wr_en         = wr_en_q;
  assign wr_addr       = wr_addr_q;
  assign wr_data       = wr_data_q;
  assign sink_3_4      = sink_3_4_q;
  assign twdl_sop_sink = twdl_q;
  assign frame_done    = done_q;
  assign frame_err     = frame_err_q;
  assign overTime      = over_time_q;
  assign cfg_err       = cfg_err_q;

endmodule
`default_nettype wire
